cajero_controlador: RTL and testbench

Transaction sequencer for the automatic cashier. It owns the customer session: card detection, 4-digit PIN capture and verification, attempt counting and lockout, amount capture, and the funds check. It commands the separate balance datapath through a one-cycle update strobe. It sits between the keypad/card front end and the balance register, and it is the only block allowed to request a balance change.

---
 rtl/cajero_controlador_pkg.sv | 21 ++
 rtl/cajero_captura_pin.sv | 49 ++++
 rtl/cajero_controlador.sv | 171 +++++++++++++++++
 tb/tb_cajero_controlador.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_controlador_pkg.sv
// Shared definitions for the cashier transaction sequencer: state encodings,
// PIN length and transaction-type encodings.
package cajero_controlador_pkg;

    // Number of keypad digits that make up a PIN.
    localparam int PIN_DIGITOS = 4;

    // tipo_trans encodings.
    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Sequencer states; plain constants so older tools and dumps read them as-is.
    localparam logic [2:0] ESPERA_TARJETA = 3'd0;
    localparam logic [2:0] PIN            = 3'd1;
    localparam logic [2:0] VERIFICAR      = 3'd2;
    localparam logic [2:0] ESPERA_MONTO   = 3'd3;
    localparam logic [2:0] EJECUTAR       = 3'd4;
    localparam logic [2:0] FIN            = 3'd5;
    localparam logic [2:0] BLOQUEADO      = 3'd6;

endpackage

// File: rtl/cajero_captura_pin.sv
// PIN capture: shifts keypad digits into a 16-bit buffer (first digit ends up
// in the MS nibble) and flags the strobe that delivers the last digit.
module cajero_captura_pin
    import cajero_controlador_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        strobe_i,
    input  logic [3:0]  digito_i,
    output logic        completo_o,
    output logic [15:0] valor_o
);

    localparam logic [1:0] ULTIMO = 2'(PIN_DIGITOS - 1);

    logic [15:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next buffer/counter: clear beats a strobe arriving in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (strobe_i) begin
            buf_d = {buf_q[11:0], digito_i};
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Buffer and digit counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign completo_o = strobe_i && !clear_i && (cnt_q == ULTIMO);
    assign valor_o    = buf_q;

endmodule

// File: rtl/cajero_controlador.sv
// Cashier transaction sequencer: card session, PIN verification with attempt
// counting and lockout, amount capture, funds check and the balance update strobe.
module cajero_controlador
    import cajero_controlador_pkg::*;
#(
    parameter int ANCHO_MONTO  = 32,
    parameter int MAX_INTENTOS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tarjeta_recibida,
    input  logic                   tipo_trans,
    input  logic                   digito_stb,
    input  logic [3:0]             digito,
    input  logic [15:0]            pin,
    input  logic                   monto_stb,
    input  logic [ANCHO_MONTO-1:0] monto,
    input  logic [ANCHO_MONTO-1:0] balance,
    output logic                   actualizar,
    output logic                   resta,
    output logic [ANCHO_MONTO-1:0] monto_out,
    output logic                   entregar_dinero,
    output logic                   pin_incorrecto,
    output logic                   advertencia,
    output logic                   bloqueo,
    output logic                   fondos_insuficientes
);

    localparam int                   ANCHO_INT = $clog2(MAX_INTENTOS + 1);
    localparam logic [ANCHO_INT-1:0] LIMITE    = ANCHO_INT'(MAX_INTENTOS);
    localparam logic [ANCHO_INT-1:0] AVISO     = ANCHO_INT'(MAX_INTENTOS - 1);

    logic [2:0]             state_q, state_d;
    logic [ANCHO_INT-1:0]   intentos_q, intentos_d;
    logic                   tipo_q, tipo_d;
    logic [ANCHO_MONTO-1:0] monto_q, monto_d;
    logic                   actualizar_q, actualizar_d;
    logic                   resta_q, resta_d;
    logic                   entregar_q, entregar_d;
    logic                   pin_inc_q, pin_inc_d;
    logic                   adv_q, adv_d;
    logic                   bloqueo_q, bloqueo_d;
    logic                   fondos_q, fondos_d;

    logic                   pin_completo;
    logic [15:0]            pin_valor;

    // The digit buffer only lives while a card sits in the PIN state; leaving
    // PIN or pulling the card wipes it, which also drops a coincident digit.
    cajero_captura_pin u_captura (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (!tarjeta_recibida || (state_q != PIN)),
        .strobe_i   (digito_stb && (state_q == PIN)),
        .digito_i   (digito),
        .completo_o (pin_completo),
        .valor_o    (pin_valor)
    );

    // Next-state and output decode; pulses default low, levels hold.
    always_comb begin
        state_d      = state_q;
        intentos_d   = intentos_q;
        tipo_d       = tipo_q;
        monto_d      = monto_q;
        resta_d      = resta_q;
        adv_d        = adv_q;
        bloqueo_d    = bloqueo_q;
        actualizar_d = 1'b0;
        entregar_d   = 1'b0;
        pin_inc_d    = 1'b0;
        fondos_d     = 1'b0;

        case (state_q)
            ESPERA_TARJETA: begin
                if (tarjeta_recibida) state_d = PIN;
            end
            PIN: begin
                if (!tarjeta_recibida)  state_d = ESPERA_TARJETA;
                else if (pin_completo)  state_d = VERIFICAR;
            end
            VERIFICAR: begin
                if (pin_valor == pin) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                    state_d    = ESPERA_MONTO;
                end else begin
                    intentos_d = intentos_q + 1'b1;
                    pin_inc_d  = 1'b1;
                    if (intentos_d == LIMITE) begin
                        bloqueo_d = 1'b1;
                        adv_d     = 1'b0;
                        state_d   = BLOQUEADO;
                    end else begin
                        if (intentos_d == AVISO) adv_d = 1'b1;
                        state_d = PIN;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (!tarjeta_recibida) begin
                    state_d = ESPERA_TARJETA;
                end else if (monto_stb) begin
                    monto_d = monto;
                    tipo_d  = tipo_trans;
                    state_d = EJECUTAR;
                end
            end
            EJECUTAR: begin
                if (tipo_q == DEPOSITO) begin
                    actualizar_d = 1'b1;
                    resta_d      = 1'b0;
                end else if (monto_q <= balance) begin
                    actualizar_d = 1'b1;
                    resta_d      = 1'b1;
                    entregar_d   = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
                state_d = FIN;
            end
            FIN: begin
                if (!tarjeta_recibida) state_d = ESPERA_TARJETA;
            end
            BLOQUEADO: begin
                bloqueo_d = 1'b1;
                adv_d     = 1'b0;
            end
            default: state_d = ESPERA_TARJETA;
        endcase
    end

    // State and registered outputs; reset clears everything including the lockout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ESPERA_TARJETA;
            intentos_q   <= '0;
            tipo_q       <= DEPOSITO;
            monto_q      <= '0;
            actualizar_q <= 1'b0;
            resta_q      <= 1'b0;
            entregar_q   <= 1'b0;
            pin_inc_q    <= 1'b0;
            adv_q        <= 1'b0;
            bloqueo_q    <= 1'b0;
            fondos_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            intentos_q   <= intentos_d;
            tipo_q       <= tipo_d;
            monto_q      <= monto_d;
            actualizar_q <= actualizar_d;
            resta_q      <= resta_d;
            entregar_q   <= entregar_d;
            pin_inc_q    <= pin_inc_d;
            adv_q        <= adv_d;
            bloqueo_q    <= bloqueo_d;
            fondos_q     <= fondos_d;
        end
    end

    assign actualizar           = actualizar_q;
    assign resta                = resta_q;
    assign monto_out            = monto_q;
    assign entregar_dinero      = entregar_q;
    assign pin_incorrecto       = pin_inc_q;
    assign advertencia          = adv_q;
    assign bloqueo              = bloqueo_q;
    assign fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_cajero_controlador.sv
// Bench for the cashier sequencer: directed sessions with literal expectations
// followed by randomized traffic compared every cycle against a session model.
module tb_cajero_controlador;

    localparam int W   = 32;
    localparam int MAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          tarjeta_recibida;
    logic          tipo_trans;
    logic          digito_stb;
    logic [3:0]    digito;
    logic [15:0]   pin;
    logic          monto_stb;
    logic [W-1:0]  monto;
    logic [W-1:0]  balance;
    logic          actualizar;
    logic          resta;
    logic [W-1:0]  monto_out;
    logic          entregar_dinero;
    logic          pin_incorrecto;
    logic          advertencia;
    logic          bloqueo;
    logic          fondos_insuficientes;

    int n_checks = 0;
    int n_err    = 0;

    cajero_controlador #(.ANCHO_MONTO(W), .MAX_INTENTOS(MAX)) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin                  (pin),
        .monto_stb            (monto_stb),
        .monto                (monto),
        .balance              (balance),
        .actualizar           (actualizar),
        .resta                (resta),
        .monto_out            (monto_out),
        .entregar_dinero      (entregar_dinero),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .fondos_insuficientes (fondos_insuficientes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- session model ----------------
    typedef enum {M_IDLE, M_ENTRY, M_CHECKING, M_AMOUNT, M_PAYING, M_DONE, M_LOCKED} mphase_t;

    mphase_t      m_phase   = M_IDLE;
    logic [3:0]   m_q[$];
    int           m_entered = 0;
    int           m_wrong   = 0;
    logic [W-1:0] m_amt     = '0;
    logic         m_is_wd   = 1'b0;
    bit           m_valid   = 0;
    bit           e_act = 0, e_resta = 0, e_ent = 0, e_pinc = 0, e_adv = 0, e_blq = 0, e_fi = 0;
    logic [W-1:0] e_mo = '0;
    bit           m_chk_mo = 0;

    always @(posedge clk) begin
        e_act = 0; e_ent = 0; e_pinc = 0; e_fi = 0; m_chk_mo = 0;
        if (reset) begin
            m_valid = 1;
            m_phase = M_IDLE;
            m_q.delete();
            m_wrong = 0;
            e_adv = 0; e_blq = 0; e_resta = 0; e_mo = '0;
            m_chk_mo = 1;
        end else begin
            case (m_phase)
                M_IDLE: if (tarjeta_recibida) begin m_q.delete(); m_phase = M_ENTRY; end
                M_ENTRY: begin
                    if (!tarjeta_recibida) begin
                        m_q.delete();
                        m_phase = M_IDLE;
                    end else if (digito_stb) begin
                        m_q.push_back(digito);
                        if (m_q.size() == 4) begin
                            m_entered = m_q[0] * 4096 + m_q[1] * 256 + m_q[2] * 16 + m_q[3];
                            m_q.delete();
                            m_phase = M_CHECKING;
                        end
                    end
                end
                M_CHECKING: begin
                    if (m_entered == int'(pin)) begin
                        m_wrong = 0;
                        e_adv   = 0;
                        m_phase = M_AMOUNT;
                    end else begin
                        m_wrong++;
                        e_pinc = 1;
                        if (m_wrong >= MAX) begin
                            e_blq = 1; e_adv = 0; m_phase = M_LOCKED;
                        end else begin
                            if (m_wrong == MAX - 1) e_adv = 1;
                            m_phase = M_ENTRY;
                        end
                    end
                end
                M_AMOUNT: begin
                    if (!tarjeta_recibida) m_phase = M_IDLE;
                    else if (monto_stb) begin
                        m_amt = monto; m_is_wd = tipo_trans; m_phase = M_PAYING;
                    end
                end
                M_PAYING: begin
                    if (!m_is_wd) begin
                        e_act = 1; e_resta = 0; e_mo = m_amt; m_chk_mo = 1;
                    end else if (m_amt <= balance) begin
                        e_act = 1; e_resta = 1; e_ent = 1; e_mo = m_amt; m_chk_mo = 1;
                    end else begin
                        e_fi = 1;
                    end
                    m_phase = M_DONE;
                end
                M_DONE:   if (!tarjeta_recibida) m_phase = M_IDLE;
                M_LOCKED: ;
                default:  m_phase = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_actualizar", W'(actualizar), W'(e_act));
            check("m_entregar",   W'(entregar_dinero), W'(e_ent));
            check("m_pin_inc",    W'(pin_incorrecto), W'(e_pinc));
            check("m_advert",     W'(advertencia), W'(e_adv));
            check("m_bloqueo",    W'(bloqueo), W'(e_blq));
            check("m_fondos",     W'(fondos_insuficientes), W'(e_fi));
            if (m_chk_mo) begin
                check("m_monto_out", monto_out, e_mo);
                check("m_resta",     W'(resta), W'(e_resta));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_card();
        tarjeta_recibida = 1'b1;
        tick();
    endtask

    task automatic remove_card();
        tarjeta_recibida = 1'b0;
        tick();
    endtask

    // Four back-to-back digits; returns when the verdict is visible.
    task automatic enter_pin(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            digito     = v[15 - 4 * k -: 4];
            digito_stb = 1'b1;
            tick();
            digito_stb = 1'b0;
        end
        tick();
    endtask

    // Amount strobe; returns in the cycle the datapath strobe is visible.
    task automatic do_tx(input logic tipo, input logic [W-1:0] amt);
        tipo_trans = tipo;
        monto      = amt;
        monto_stb  = 1'b1;
        tick();
        monto_stb  = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_actualizar"}, W'(actualizar), '0);
        check({tag, "_resta"},      W'(resta), '0);
        check({tag, "_monto_out"},  monto_out, '0);
        check({tag, "_entregar"},   W'(entregar_dinero), '0);
        check({tag, "_pin_inc"},    W'(pin_incorrecto), '0);
        check({tag, "_advert"},     W'(advertencia), '0);
        check({tag, "_bloqueo"},    W'(bloqueo), '0);
        check({tag, "_fondos"},     W'(fondos_insuficientes), '0);
    endtask

    initial begin
        reset = 1'b1; tarjeta_recibida = 1'b0; tipo_trans = 1'b0; digito_stb = 1'b0;
        digito = '0; pin = 16'h1234; monto_stb = 1'b0; monto = '0; balance = 32'd1000;
        tick(); tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Normal withdrawal.
        insert_card();
        enter_pin(16'h1234);
        check("wd_pin_ok", W'(pin_incorrecto), '0);
        do_tx(1'b1, 32'd500);
        check("wd_act",  W'(actualizar), 32'd1);
        check("wd_resta", W'(resta), 32'd1);
        check("wd_monto", monto_out, 32'd500);
        check("wd_ent",  W'(entregar_dinero), 32'd1);
        check("wd_fi",   W'(fondos_insuficientes), '0);
        tick();
        check("wd_act_once", W'(actualizar), '0);
        check("wd_ent_once", W'(entregar_dinero), '0);
        remove_card();

        // Insufficient funds.
        insert_card();
        enter_pin(16'h1234);
        do_tx(1'b1, 32'd1001);
        check("nf_fi",  W'(fondos_insuficientes), 32'd1);
        check("nf_act", W'(actualizar), '0);
        check("nf_ent", W'(entregar_dinero), '0);
        tick();
        check("nf_fi_once", W'(fondos_insuficientes), '0);
        remove_card();

        // Deposit at full scale.
        insert_card();
        enter_pin(16'h1234);
        do_tx(1'b0, 32'hFFFF_FFFF);
        check("dep_act",   W'(actualizar), 32'd1);
        check("dep_resta", W'(resta), '0);
        check("dep_monto", monto_out, 32'hFFFF_FFFF);
        remove_card();

        // Attempts survive card removal.
        insert_card();
        enter_pin(16'h0000);
        check("surv_pinc1", W'(pin_incorrecto), 32'd1);
        check("surv_adv1",  W'(advertencia), '0);
        enter_pin(16'h0000);
        check("surv_pinc2", W'(pin_incorrecto), 32'd1);
        check("surv_adv2",  W'(advertencia), 32'd1);
        remove_card();
        check("surv_adv_removed", W'(advertencia), 32'd1);
        insert_card();
        enter_pin(16'h1234);
        check("surv_adv_cleared", W'(advertencia), '0);
        check("surv_pinc_ok",     W'(pin_incorrecto), '0);
        do_tx(1'b0, 32'd5);
        check("surv_amount_stage", W'(actualizar), 32'd1);
        remove_card();

        // Removal coinciding with a digit strobe after two digits.
        insert_card();
        for (int k = 1; k <= 2; k++) begin
            digito = 4'(k); digito_stb = 1'b1; tick(); digito_stb = 1'b0;
        end
        digito = 4'd3; digito_stb = 1'b1; tarjeta_recibida = 1'b0;
        tick();
        digito_stb = 1'b0;
        insert_card();
        enter_pin(16'h1234);
        check("mid_fresh_pin", W'(pin_incorrecto), '0);
        do_tx(1'b0, 32'd7);
        check("mid_fresh_act", W'(actualizar), 32'd1);
        remove_card();

        // Lockout after three wrong PINs.
        insert_card();
        enter_pin(16'h0000);
        check("lk_pinc1", W'(pin_incorrecto), 32'd1);
        enter_pin(16'h0000);
        check("lk_pinc2", W'(pin_incorrecto), 32'd1);
        check("lk_adv2",  W'(advertencia), 32'd1);
        enter_pin(16'h0000);
        check("lk_pinc3", W'(pin_incorrecto), 32'd1);
        check("lk_blq3",  W'(bloqueo), 32'd1);
        check("lk_adv3",  W'(advertencia), '0);
        enter_pin(16'h1234);
        check("lk_ignore_pin", W'(pin_incorrecto), '0);
        do_tx(1'b0, 32'd9);
        check("lk_ignore_tx", W'(actualizar), '0);
        remove_card();
        insert_card();
        check("lk_sticky", W'(bloqueo), 32'd1);

        // Reset while locked.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst_lock");
        tick();
        enter_pin(16'h1234);
        check("rst_pin_ok", W'(pin_incorrecto), '0);
        do_tx(1'b1, 32'd100);
        check("rst_wd_act", W'(actualizar), 32'd1);
        check("rst_wd_ent", W'(entregar_dinero), 32'd1);
        remove_card();

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 6000; c++) begin
            reset = ((m_phase == M_LOCKED) && ($urandom_range(0, 15) == 0)) ||
                    ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 39) == 0) tarjeta_recibida = !tarjeta_recibida;
            if (!tarjeta_recibida && ($urandom_range(0, 3) == 0)) pin = 16'($urandom);
            digito_stb = ($urandom_range(0, 2) == 0);
            if (($urandom_range(0, 4) == 0) || (m_q.size() >= 4))
                digito = 4'($urandom);
            else
                digito = pin[15 - 4 * m_q.size() -: 4];
            monto_stb  = ($urandom_range(0, 5) == 0);
            tipo_trans = 1'($urandom);
            monto   = ($urandom_range(0, 7) == 0) ? $urandom : W'($urandom_range(0, 2000));
            balance = ($urandom_range(0, 7) == 0) ? $urandom : W'($urandom_range(0, 2000));
            tick();
        end
        reset = 1'b0; digito_stb = 1'b0; monto_stb = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
